// File: rtl/led_counter_ctrl.sv
// LED counter controller: command interface drives an 8-bit counter that steps every
// `period` clock cycles while running. Optional down-counting is enabled by LED_CTRL_DOWN_EN.
//
// state | meaning
// IDLE  | counter frozen: leds and prescaler hold, tick stays low
// RUN   | prescaler advances every cycle; leds steps on each terminal count
module led_counter_ctrl #(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned DEF_PERIOD = CLK_FREQ / 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic [7:0]  leds,
    output logic        tick,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0]  OP_START      = 2'b00;
    localparam logic [1:0]  OP_STOP       = 2'b01;
    localparam logic [1:0]  OP_LOAD       = 2'b10;
    localparam logic [1:0]  OP_SET_PERIOD = 2'b11;
    localparam logic [31:0] PERIOD_RST    = 32'(DEF_PERIOD);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] presc;
    logic [31:0] presc_nxt;
    logic [31:0] period;
    logic [31:0] period_nxt;
    logic [7:0]  leds_nxt;
    logic [7:0]  leds_step;
    logic        tick_nxt;
    logic        ready_nxt;
    logic        accept;
    logic        terminal;

    assign accept    = cmd_valid & cmd_ready;
    assign terminal  = (state == RUN) && (presc == (period - 32'd1));
    assign busy      = (state == RUN);
    assign ready_nxt = ~accept;

`ifdef LED_CTRL_DOWN_EN
    logic dir_down;
    logic dir_down_nxt;

    assign leds_step = dir_down ? (leds - 8'd1) : (leds + 8'd1);

    // Direction is taken from every accepted START, including one issued while running.
    always_comb begin
        dir_down_nxt = dir_down;
        if (accept && (cmd_op == OP_START)) begin
            dir_down_nxt = cmd_data[8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_down <= 1'b0;
        end else begin
            dir_down <= dir_down_nxt;
        end
    end
`else
    assign leds_step = leds + 8'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Free-running progress first; an accepted command then overrides it, so STOP, LOAD
    // and SET_PERIOD suppress a coincident step while START in RUN lets it through.
    always_comb begin
        state_nxt  = state;
        presc_nxt  = presc;
        period_nxt = period;
        leds_nxt   = leds;
        tick_nxt   = 1'b0;

        if (state == RUN) begin
            if (terminal) begin
                presc_nxt = '0;
                leds_nxt  = leds_step;
                tick_nxt  = 1'b1;
            end else begin
                presc_nxt = presc + 32'd1;
            end
        end

        if (accept) begin
            case (cmd_op)
                OP_START: begin
                    if (state == IDLE) begin
                        state_nxt = RUN;
                        presc_nxt = '0;
                    end
                end
                OP_STOP: begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                    leds_nxt  = leds;
                    tick_nxt  = 1'b0;
                end
                OP_LOAD: begin
                    presc_nxt = '0;
                    leds_nxt  = cmd_data[7:0];
                    tick_nxt  = 1'b0;
                end
                OP_SET_PERIOD: begin
                    presc_nxt  = '0;
                    period_nxt = (cmd_data == 32'd0) ? 32'd1 : cmd_data;
                    leds_nxt   = leds;
                    tick_nxt   = 1'b0;
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            period    <= PERIOD_RST;
            leds      <= '0;
            tick      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            presc     <= presc_nxt;
            period    <= period_nxt;
            leds      <= leds_nxt;
            tick      <= tick_nxt;
            cmd_ready <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Testbench for led_counter_ctrl: directed scenarios with literal expectations plus a
// randomized command stream compared every cycle against a cycles-until-step model.
module tb_led_counter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [7:0]  leds;
    logic        tick;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    led_counter_ctrl #(
        .CLK_FREQ   (25_000_000),
        .DEF_PERIOD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .leds      (leds),
        .tick      (tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts remaining edges until the next step instead of a prescaler.
    logic [7:0]  m_leds;
    logic        m_run, m_tick, m_ready, m_dir;
    logic        m_acc, m_step, m_dir_old;
    int unsigned m_period, m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_leds = 8'd0; m_run = 1'b0; m_tick = 1'b0; m_ready = 1'b1;
            m_dir = 1'b0; m_period = 4; m_left = 0;
        end else begin
            m_acc     = cmd_valid && m_ready;
            m_step    = m_run && (m_left == 1);
            m_dir_old = m_dir;
            if (m_run) m_left = m_step ? m_period : m_left - 1;
            if (m_acc) begin
                case (cmd_op)
                    2'd0: begin
                        if (!m_run) begin
                            m_run  = 1'b1;
                            m_left = m_period;
                        end
`ifdef LED_CTRL_DOWN_EN
                        m_dir = cmd_data[8];
`endif
                    end
                    2'd1: begin m_run = 1'b0; m_step = 1'b0; end
                    2'd2: begin m_leds = cmd_data[7:0]; m_left = m_period; m_step = 1'b0; end
                    default: begin
                        m_period = (cmd_data == 32'd0) ? 1 : cmd_data;
                        m_left   = m_period;
                        m_step   = 1'b0;
                    end
                endcase
            end
            if (m_step) m_leds = m_dir_old ? m_leds - 8'd1 : m_leds + 8'd1;
            m_tick  = m_step;
            m_ready = !m_acc;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("model_leds",  32'(leds),      32'(m_leds));
            check("model_tick",  32'(tick),      32'(m_tick));
            check("model_busy",  32'(busy),      32'(m_run));
            check("model_ready", 32'(cmd_ready), 32'(m_ready));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] data);
        int n = 0;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout actual=0 expected=1 at %0t", $time);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    int ticks;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 32'd0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_leds",  32'(leds),      32'd0);
        check("rst_tick",  32'(tick),      32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);

        // Basic count: START accepted at edge 0
        send(2'd0, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("basic_leds", 32'(leds), 32'(k / 4));
            check("basic_tick", 32'(tick), 32'((k % 4) == 0));
            check("basic_busy", 32'(busy), 32'd1);
        end

        // Up wrap
        apply_reset();
        send(2'd2, 32'h0000_00FE);
        send(2'd0, 32'd0);
        check("wrap_start", 32'(leds), 32'hFE);
        ticks = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (tick) ticks++;
            if (k == 4) check("wrap_ff", 32'(leds), 32'hFF);
            if (k == 8) check("wrap_00", 32'(leds), 32'h00);
        end
        check("wrap_ticks", 32'(ticks), 32'd2);

        // Collision: STOP on the edge where the prescaler is 3
        apply_reset();
        send(2'd0, 32'd0);
        repeat (3) @(negedge clk);
        send(2'd1, 32'd0);
        check("coll_leds",  32'(leds),      32'd0);
        check("coll_tick",  32'(tick),      32'd0);
        check("coll_busy",  32'(busy),      32'd0);
        check("coll_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("coll_ready_back", 32'(cmd_ready), 32'd1);

        // SET_PERIOD 0 while running
        apply_reset();
        send(2'd0, 32'd0);
        send(2'd3, 32'd0);
        check("per1_tick0", 32'(tick), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("per1_leds", 32'(leds), 32'(k));
            check("per1_tick", 32'(tick), 32'd1);
        end

        // Reset mid-run with leds=5
        apply_reset();
        send(2'd2, 32'd5);
        send(2'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("mid_leds_pre", 32'(leds), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_leds", 32'(leds),      32'd0);
        check("mid_busy", 32'(busy),      32'd0);
        check("mid_tick", 32'(tick),      32'd0);
        check("mid_rdy",  32'(cmd_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("mid_idle", 32'(busy), 32'd0);
        send(2'd0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("mid_restart", 32'(leds), 32'(k / 4));
        end

`ifdef LED_CTRL_DOWN_EN
        apply_reset();
        send(2'd2, 32'd1);
        send(2'd0, 32'h0000_0100);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) check("down_hold", 32'(leds), 32'h01);
            if (k == 4) check("down_00",   32'(leds), 32'h00);
            if (k == 8) check("down_ff",   32'(leds), 32'hFF);
            check("down_tick", 32'(tick), 32'((k % 4) == 0));
        end
`endif

        // Randomized command stream, checked every cycle by the model
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            cmd_valid = ($urandom_range(0, 9) < 3);
            if (r < 4) begin
                cmd_op   = 2'd0;
                cmd_data = $urandom;
            end else if (r == 4) begin
                cmd_op   = 2'd1;
                cmd_data = $urandom;
            end else if (r < 7) begin
                cmd_op   = 2'd2;
                cmd_data = $urandom;
            end else begin
                cmd_op   = 2'd3;
                cmd_data = $urandom_range(0, 6);
            end
            if (i == 1500) begin
                cmd_valid = 1'b0;
                #3 rst_n = 1'b0;
                #1 check("rand_rst_leds", 32'(leds), 32'd0);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
